// File: rtl/can_bit_destuff_ctrl.sv
// rtl/can_bit_destuff_ctrl.sv - CAN/CAN-FD receive destuffer: drops dynamic and fixed stuff bits, flags stuff errors
module can_bit_destuff_ctrl #(
    parameter int STUFF_LEN = 5,
    parameter int FIXED_LEN = 4,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample_point,
    input  logic             bit_in,
    input  logic             frame_start,
    input  logic             stuff_en,
    input  logic             fixed_mode,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             stuff_removed,
    output logic             stuff_err,
    output logic             err_lock,
    output logic [CNT_W-1:0] stuff_cnt
);
    localparam logic [3:0] STUFF_L = 4'(STUFF_LEN);
    localparam logic [3:0] FIXED_L = 4'(FIXED_LEN);

    logic             last_bit, fix_pend, fixed_q;
    logic [3:0]       run_len, fix_cnt;

    // c_* is the state this sample sees: frame_start clears it before the bit is processed
    logic             c_last, c_fpend, c_fixed, c_lock;
    logic [3:0]       c_run, c_fcnt;
    logic [CNT_W-1:0] c_cnt;

    logic             last_n, fpend_n, fixed_n, lock_n, out_n, valid_n, rem_n, err_n;
    logic [3:0]       run_n, fcnt_n;
    logic [CNT_W-1:0] cnt_n;
    logic             pend_eff;

    always_comb begin
        c_last  = frame_start ? 1'b1 : last_bit;
        c_run   = frame_start ? 4'd0 : run_len;
        c_fcnt  = frame_start ? 4'd0 : fix_cnt;
        c_fpend = frame_start ? 1'b0 : fix_pend;
        c_fixed = frame_start ? 1'b0 : fixed_q;
        c_lock  = frame_start ? 1'b0 : err_lock;
        c_cnt   = frame_start ? '0   : stuff_cnt;

        last_n   = c_last;
        run_n    = c_run;
        fcnt_n   = c_fcnt;
        fpend_n  = c_fpend;
        fixed_n  = c_fixed;
        lock_n   = c_lock;
        cnt_n    = c_cnt;
        out_n    = bit_out;
        valid_n  = 1'b0;
        rem_n    = 1'b0;
        err_n    = 1'b0;
        pend_eff = 1'b0;

        if (sample_point && !c_lock) begin
            if (!stuff_en) begin
                valid_n = 1'b1;
                out_n   = bit_in;
                run_n   = 4'd0;
                fcnt_n  = 4'd0;
                fpend_n = 1'b0;
                fixed_n = 1'b0;
                last_n  = bit_in;
            end else if (fixed_mode) begin
                // entering fixed mode makes the very first fixed-mode bit a stuff bit
                pend_eff = c_fpend || !c_fixed;
                fixed_n  = 1'b1;
                run_n    = 4'd0;
                last_n   = bit_in;
                if (pend_eff) begin
                    if (bit_in != c_last) begin
                        rem_n   = 1'b1;
                        fcnt_n  = 4'd0;
                        fpend_n = 1'b0;
                    end else begin
                        err_n   = 1'b1;
                        lock_n  = 1'b1;
                        fpend_n = 1'b1;
                    end
                end else begin
                    valid_n = 1'b1;
                    out_n   = bit_in;
                    fcnt_n  = c_fcnt + 4'd1;
                    if (c_fcnt + 4'd1 == FIXED_L)
                        fpend_n = 1'b1;
                end
            end else begin
                fixed_n = 1'b0;
                fcnt_n  = 4'd0;
                fpend_n = 1'b0;
                if (c_run < STUFF_L) begin
                    valid_n = 1'b1;
                    out_n   = bit_in;
                    run_n   = (bit_in == c_last && c_run != 4'd0) ? c_run + 4'd1 : 4'd1;
                    last_n  = bit_in;
                end else if (bit_in != c_last) begin
                    rem_n  = 1'b1;
                    cnt_n  = c_cnt + CNT_W'(1);
                    run_n  = 4'd1;
                    last_n = bit_in;
                end else begin
                    err_n  = 1'b1;
                    lock_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_out       <= 1'b1;
            bit_valid     <= 1'b0;
            stuff_removed <= 1'b0;
            stuff_err     <= 1'b0;
            err_lock      <= 1'b0;
            stuff_cnt     <= '0;
            last_bit      <= 1'b1;
            run_len       <= 4'd0;
            fix_cnt       <= 4'd0;
            fix_pend      <= 1'b0;
            fixed_q       <= 1'b0;
        end else begin
            bit_out       <= out_n;
            bit_valid     <= valid_n;
            stuff_removed <= rem_n;
            stuff_err     <= err_n;
            err_lock      <= lock_n;
            stuff_cnt     <= cnt_n;
            last_bit      <= last_n;
            run_len       <= run_n;
            fix_cnt       <= fcnt_n;
            fix_pend      <= fpend_n;
            fixed_q       <= fixed_n;
        end
    end
endmodule
